// File: rtl/branch_dispatch.sv
// Issue stage in front of the branch unit: evaluates ARM condition codes at accept,
// holds branch controls until the unit's PC write is seen, and forwards all other words.
module branch_dispatch #(
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic [3:0]  flags,
    output logic        br_en,
    output logic        br_cond,
    output logic        br_link,
    output logic [23:0] br_offset,
    input  logic        br_wr_en,
    input  logic [3:0]  br_wr_reg,
    output logic        dp_valid,
    output logic [31:0] dp_instr,
    output logic        dp_cond,
    input  logic        dp_ready,
    output logic        busy,
    output logic        err_timeout
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FWD   = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_br_en;
    logic          r_br_cond;
    logic          r_br_link;
    logic [23:0]   r_br_offset;
    logic          r_dp_valid;
    logic [31:0]   r_dp_instr;
    logic          r_dp_cond;
    logic          r_err;

    logic w_n, w_z, w_c, w_v;
    logic w_pass;
    logic w_is_br;
    logic w_pc_wr;

    assign {w_n, w_z, w_c, w_v} = flags;
    assign w_is_br = (instr[27:25] == 3'b101);
    assign w_pc_wr = br_wr_en && (br_wr_reg == 4'd15);

    always_comb begin
        w_pass = 1'b0;
        case (instr[31:28])
            4'h0: w_pass = w_z;
            4'h1: w_pass = !w_z;
            4'h2: w_pass = w_c;
            4'h3: w_pass = !w_c;
            4'h4: w_pass = w_n;
            4'h5: w_pass = !w_n;
            4'h6: w_pass = w_v;
            4'h7: w_pass = !w_v;
            4'h8: w_pass = w_c && !w_z;
            4'h9: w_pass = !w_c || w_z;
            4'hA: w_pass = (w_n == w_v);
            4'hB: w_pass = (w_n != w_v);
            4'hC: w_pass = !w_z && (w_n == w_v);
            4'hD: w_pass = w_z || (w_n != w_v);
            4'hE: w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_br_en     <= 1'b0;
            r_br_cond   <= 1'b0;
            r_br_link   <= 1'b0;
            r_br_offset <= '0;
            r_dp_valid  <= 1'b0;
            r_dp_instr  <= '0;
            r_dp_cond   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        if (w_is_br) begin
                            r_br_en     <= 1'b1;
                            r_br_cond   <= w_pass;
                            r_br_link   <= instr[24];
                            r_br_offset <= instr[23:0];
                            r_cnt       <= '0;
                            r_state     <= S_WAIT;
                        end else begin
                            r_dp_valid <= 1'b1;
                            r_dp_instr <= instr;
                            r_dp_cond  <= w_pass;
                            r_state    <= S_FWD;
                        end
                    end
                end
                S_WAIT: begin
                    // Only an r15 write ends the branch; a BL link write to r14 must not.
                    if (w_pc_wr) begin
                        r_br_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_br_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DRAIN: r_state <= S_IDLE;
                S_FWD: begin
                    if (dp_ready) begin
                        r_dp_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = (r_state == S_IDLE) && rst_n;
    assign busy        = (r_state != S_IDLE);
    assign br_en       = r_br_en;
    assign br_cond     = r_br_cond;
    assign br_link     = r_br_link;
    assign br_offset   = r_br_offset;
    assign dp_valid    = r_dp_valid;
    assign dp_instr    = r_dp_instr;
    assign dp_cond     = r_dp_cond;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_branch_dispatch.sv
// Directed bench for branch_dispatch: branch issue/completion, forwarding, condition table,
// timeout recovery and asynchronous reset mid-branch.
module tb_branch_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [3:0]  flags;
    logic        br_en, br_cond, br_link;
    logic [23:0] br_offset;
    logic        br_wr_en;
    logic [3:0]  br_wr_reg;
    logic        dp_valid;
    logic [31:0] dp_instr;
    logic        dp_cond;
    logic        dp_ready;
    logic        busy;
    logic        err_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int issues  = 0;
    logic prev_en = 1'b0;

    branch_dispatch #(.TIMEOUT(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready), .flags(flags),
        .br_en(br_en), .br_cond(br_cond), .br_link(br_link), .br_offset(br_offset),
        .br_wr_en(br_wr_en), .br_wr_reg(br_wr_reg),
        .dp_valid(dp_valid), .dp_instr(dp_instr), .dp_cond(dp_cond), .dp_ready(dp_ready),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Count rising edges of br_en, sampled away from the active edge.
    always @(negedge clk) begin
        if (br_en && !prev_en) issues++;
        prev_en <= br_en;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'd0:  return z == 1'b1;
            4'd1:  return z == 1'b0;
            4'd2:  return cf == 1'b1;
            4'd3:  return cf == 1'b0;
            4'd4:  return n == 1'b1;
            4'd5:  return n == 1'b0;
            4'd6:  return v == 1'b1;
            4'd7:  return v == 1'b0;
            4'd8:  return (cf == 1'b1) && (z == 1'b0);
            4'd9:  return (cf == 1'b0) || (z == 1'b1);
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return (z == 1'b0) && (n == v);
            4'd13: return (z == 1'b1) || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; flags = '0;
        br_wr_en = 1'b0; br_wr_reg = '0; dp_ready = 1'b0;
        step(); step();
        n_tests++;
        if ({instr_ready, br_en, br_cond, br_link, br_offset, dp_valid, dp_instr, dp_cond, busy, err_timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b en=%b cond=%b link=%b off=%h dpv=%b dpi=%h dpc=%b busy=%b err=%b, want all 0",
                     instr_ready, br_en, br_cond, br_link, br_offset, dp_valid, dp_instr, dp_cond, busy, err_timeout);
        end
        #2 rst_n = 1'b1;
        step();
        n_tests++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b busy=%b, want 1 0", instr_ready, busy);
        end
    endtask

    task automatic test_branch_al();
        instr = 32'hEA000010; flags = 4'b0000; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        n_tests++;
        if ({br_en, br_cond, br_link, br_offset, instr_ready, busy} !== {1'b1, 1'b1, 1'b0, 24'h000010, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL b_al_issue: en=%b cond=%b link=%b off=%h rdy=%b busy=%b, want 1 1 0 000010 0 1",
                     br_en, br_cond, br_link, br_offset, instr_ready, busy);
        end
        step(); step(); step();
        n_tests++;
        if (br_en !== 1'b1 || br_offset !== 24'h000010) begin
            n_fail++;
            $display("FAIL b_al_hold: en=%b off=%h, want 1 000010", br_en, br_offset);
        end
        br_wr_en = 1'b1; br_wr_reg = 4'd15;
        step();
        br_wr_en = 1'b0; br_wr_reg = 4'd0;
        n_tests++;
        if (br_en !== 1'b0 || instr_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b_al_drop: en=%b rdy=%b busy=%b, want 0 0 1", br_en, instr_ready, busy);
        end
        step();
        n_tests++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b_al_idle: rdy=%b busy=%b, want 1 0", instr_ready, busy);
        end
    endtask

    task automatic test_bl_link_ignored();
        int start_issues;
        start_issues = issues;
        instr = 32'h0B0000FF; flags = 4'b0000; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        flags = 4'b0100;  // Z now set; must not affect the issued branch
        n_tests++;
        if ({br_en, br_cond, br_link, br_offset} !== {1'b1, 1'b0, 1'b1, 24'h0000FF}) begin
            n_fail++;
            $display("FAIL bl_issue: en=%b cond=%b link=%b off=%h, want 1 0 1 0000ff", br_en, br_cond, br_link, br_offset);
        end
        step();
        br_wr_en = 1'b1; br_wr_reg = 4'd14;
        step();
        br_wr_en = 1'b0;
        n_tests++;
        if (br_en !== 1'b1 || br_cond !== 1'b0) begin
            n_fail++;
            $display("FAIL bl_r14_ignored: en=%b cond=%b, want 1 0", br_en, br_cond);
        end
        step();
        br_wr_en = 1'b1; br_wr_reg = 4'd15;
        step();
        br_wr_en = 1'b0; br_wr_reg = 4'd0;
        n_tests++;
        if (br_en !== 1'b0) begin
            n_fail++;
            $display("FAIL bl_r15_drop: en=%b, want 0", br_en);
        end
        step(); step(); step();
        flags = 4'b0000;
        n_tests++;
        if (issues - start_issues !== 1 || br_en !== 1'b0) begin
            n_fail++;
            $display("FAIL bl_single_issue: issues=%0d en=%b, want 1 0", issues - start_issues, br_en);
        end
    endtask

    task automatic test_forward_stall();
        instr = 32'hE3A00001; flags = 4'b0000; instr_valid = 1'b1; dp_ready = 1'b0;
        step();
        instr = 32'hE3A00002;  // next word waits while the stage is stalled
        n_tests++;
        if ({dp_valid, dp_instr, dp_cond, instr_ready, br_en} !== {1'b1, 32'hE3A00001, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL fwd_issue: v=%b instr=%h cond=%b rdy=%b en=%b, want 1 e3a00001 1 0 0",
                     dp_valid, dp_instr, dp_cond, instr_ready, br_en);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (dp_valid !== 1'b1 || dp_instr !== 32'hE3A00001 || instr_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL fwd_stall_%0d: v=%b instr=%h rdy=%b, want 1 e3a00001 0", i, dp_valid, dp_instr, instr_ready);
            end
        end
        instr_valid = 1'b0; dp_ready = 1'b1;
        step();
        dp_ready = 1'b0;
        n_tests++;
        if (dp_valid !== 1'b0 || instr_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_release: v=%b rdy=%b busy=%b, want 0 1 0", dp_valid, instr_ready, busy);
        end
    endtask

    task automatic test_cond_table();
        logic [3:0] c, f;
        logic       exp;
        for (int ci = 0; ci < 16; ci++) begin
            for (int fi = 0; fi < 16; fi++) begin
                c = 4'(ci); f = 4'(fi);
                exp = cond_ok(c, f);
                instr = {c, 4'b0001, 24'h00A5A5}; flags = f; instr_valid = 1'b1; dp_ready = 1'b0;
                step();
                instr_valid = 1'b0;
                n_tests++;
                if (dp_valid !== 1'b1 || dp_cond !== exp) begin
                    n_fail++;
                    $display("FAIL cond_c%h_f%h: v=%b dp_cond=%b, want 1 %b", c, f, dp_valid, dp_cond, exp);
                end
                dp_ready = 1'b1;
                step();
                dp_ready = 1'b0;
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        instr = 32'hEA000000; flags = 4'b0000; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        n = 0;
        while (br_en === 1'b1 && n < 100) begin
            n++;
            step();
        end
        n_tests++;
        if (n !== 32 || err_timeout !== 1'b1 || br_en !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout: high_cycles=%0d err=%b en=%b, want 32 1 0", n, err_timeout, br_en);
        end
        step();
        n_tests++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_idle: rdy=%b busy=%b, want 1 0", instr_ready, busy);
        end
        instr = 32'h13A00005; flags = 4'b0100; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        n_tests++;
        if (dp_valid !== 1'b1 || dp_instr !== 32'h13A00005 || dp_cond !== 1'b0 || err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_recover: v=%b instr=%h cond=%b err=%b, want 1 13a00005 0 1", dp_valid, dp_instr, dp_cond, err_timeout);
        end
        dp_ready = 1'b1;
        step();
        dp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_branch();
        instr = 32'hEA000123; flags = 4'b0000; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({br_en, br_cond, br_offset, instr_ready, busy, err_timeout, dp_valid, dp_instr} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: en=%b cond=%b off=%h rdy=%b busy=%b err=%b dpv=%b dpi=%h, want all 0",
                     br_en, br_cond, br_offset, instr_ready, busy, err_timeout, dp_valid, dp_instr);
        end
        step();
        #2 rst_n = 1'b1;
        step();
        instr = 32'hEB000042; flags = 4'b0000; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        n_tests++;
        if ({br_en, br_cond, br_link, br_offset} !== {1'b1, 1'b1, 1'b1, 24'h000042}) begin
            n_fail++;
            $display("FAIL reset_reissue: en=%b cond=%b link=%b off=%h, want 1 1 1 000042", br_en, br_cond, br_link, br_offset);
        end
        br_wr_en = 1'b1; br_wr_reg = 4'd15;
        step();
        br_wr_en = 1'b0;
        step();
        n_tests++;
        if (br_en !== 1'b0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_reissue_done: en=%b rdy=%b, want 0 1", br_en, instr_ready);
        end
    endtask

    initial begin
        test_reset();
        test_branch_al();
        test_bl_link_ignored();
        test_forward_stall();
        test_cond_table();
        test_timeout();
        test_reset_mid_branch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
